// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline stall/flush controller.
package pipe_pkg;
    typedef enum logic {PC_IDLE, PC_MDU_BUSY} state_e;
    localparam int REG_W_DEF = 5;
    localparam int MDU_CNT_W = 8;
    // all-zero word is sll $0,$0,0, the canonical MIPS NOP injected by idex_bubble
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;
endpackage

// File: rtl/mdu_timer.sv
// mdu_timer: MDU occupancy down-counter; owns the IDLE/MDU_BUSY state bit.
module mdu_timer
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic busy_o
);
    state_e               state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic                 done;

    assign busy_o = (state_q == PC_MDU_BUSY);
    assign done   = busy_o && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            state_d = PC_MDU_BUSY;
            cnt_d   = MDU_CNT_W'(MDU_LAT - 1);
        end else if (busy_o) begin
            state_d = done ? PC_IDLE : PC_MDU_BUSY;
            cnt_d   = done ? cnt_q : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: load-use / branch-flush / MDU-occupancy stall controller for the 5-stage pipeline.
// Optional PIPE_CTRL_PERF_EN adds saturating stall_cnt and flush_cnt counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int REG_W   = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             id_branch_taken,
    input  logic             id_mdu_start,
    input  logic             id_mdu_use,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mdu_go,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt,
`endif
    output logic             mdu_busy
);
    logic load_hz, mdu_hz, stall, hold;

    mdu_timer #(.MDU_LAT(MDU_LAT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (mdu_go),
        .busy_o (mdu_busy)
    );

    assign load_hz = ex_mem_read && (ex_rd != '0) && (ex_rd == id_rs || ex_rd == id_rt);
    assign mdu_hz  = mdu_busy && (id_mdu_start || id_mdu_use);
    assign stall   = load_hz || mdu_hz;
    // reset presents the same frozen-pipeline enables as a stall
    assign hold    = rst || stall;

    always_comb begin
        pc_write    = !hold;
        ifid_write  = !hold;
        idex_bubble = hold;
        ifid_flush  = !hold && id_branch_taken;
        mdu_go      = !hold && id_mdu_start && !mdu_busy;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
            flush_cnt_q <= (ifid_flush && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl with MDU_LAT = 4.
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       ex_mem_read = 1'b0, id_branch_taken = 1'b0, id_mdu_start = 1'b0, id_mdu_use = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, mdu_go, mdu_busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    typedef struct {
        int         id;
        logic [5:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_stalls = 0;
    int   exp_flushes = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MDU_LAT(4), .REG_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .id_branch_taken (id_branch_taken),
        .id_mdu_start    (id_mdu_start),
        .id_mdu_use      (id_mdu_use),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .mdu_go          (mdu_go),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
`endif
        .mdu_busy        (mdu_busy)
    );

    // expected word order: {pc_write, ifid_write, ifid_flush, idex_bubble, mdu_go, mdu_busy}
    task automatic drv(input int id, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic mr, input logic br, input logic ms,
                       input logic mu, input logic [5:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; ex_rd = rd;
        ex_mem_read = mr; id_branch_taken = br; id_mdu_start = ms; id_mdu_use = mu;
        x.id = id;
        x.v  = e;
        q.push_back(x);
        if (!r && e[2]) exp_stalls++;
        if (e[3]) exp_flushes++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic [5:0] got;
            x   = q.pop_front();
            got = {pc_write, ifid_write, ifid_flush, idex_bubble, mdu_go, mdu_busy};
            total++;
            if (got !== x.v) begin
                bad++;
                $display("FAIL vec%0d: got %b required %b", x.id, got, x.v);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        //      id  rst rs  rt  rd  mr br ms mu  expected
        drv( 1, 1, 0,  0,  0,  0, 0, 0, 0, 6'b000100); // reset holds pipeline
        drv( 2, 0, 0,  0,  0,  0, 0, 0, 0, 6'b110000); // free flow
        drv( 3, 0, 8,  0,  8,  1, 0, 0, 0, 6'b000100); // load-use on rs
        drv( 4, 0, 8,  0,  8,  0, 0, 0, 0, 6'b110000); // load advanced
        drv( 5, 0, 0,  0,  0,  1, 0, 0, 0, 6'b110000); // $zero never hazards
        drv( 6, 0, 1,  9,  9,  1, 0, 0, 0, 6'b000100); // load-use on rt
        drv( 7, 0, 0,  0,  0,  0, 1, 0, 0, 6'b111000); // taken branch flush
        drv( 8, 0, 3,  0,  3,  1, 1, 0, 0, 6'b000100); // branch masked by stall
        drv( 9, 0, 3,  0,  3,  0, 1, 0, 0, 6'b111000); // branch re-resolves
        drv(10, 0, 0,  0,  0,  0, 0, 1, 0, 6'b110010); // mult issue
        drv(11, 0, 0,  0,  0,  0, 0, 0, 1, 6'b000101); // mflo stalls busy 1
        drv(12, 0, 0,  0,  0,  0, 0, 0, 1, 6'b000101);
        drv(13, 0, 0,  0,  0,  0, 0, 0, 1, 6'b000101);
        drv(14, 0, 0,  0,  0,  0, 0, 0, 1, 6'b000101); // busy 4
        drv(15, 0, 0,  0,  0,  0, 0, 0, 1, 6'b110000); // mflo proceeds
        drv(16, 0, 0,  0,  0,  0, 0, 1, 0, 6'b110010); // mult issue
        drv(17, 0, 0,  0,  0,  0, 0, 0, 0, 6'b110001); // add flows during busy
        drv(18, 0, 0,  0,  0,  0, 0, 1, 0, 6'b000101); // 2nd mult stalls
        drv(19, 0, 4,  0,  4,  1, 0, 1, 0, 6'b000101); // load_hz + mdu_hz single stall
        drv(20, 0, 0,  0,  0,  0, 0, 1, 0, 6'b000101); // last busy cycle
        drv(21, 0, 0,  0,  0,  0, 0, 1, 0, 6'b110010); // go on first idle cycle
        drv(22, 0, 0,  0,  0,  0, 0, 0, 0, 6'b110001);
        drv(23, 1, 0,  0,  0,  0, 0, 1, 0, 6'b000101); // reset mid-busy, no go
        drv(24, 0, 0,  0,  0,  0, 0, 0, 0, 6'b110000); // operation abandoned
        drv(25, 0, 0,  0,  0,  0, 0, 1, 0, 6'b110010); // fresh issue after reset
        drv(26, 0, 0,  0,  0,  0, 0, 0, 0, 6'b110001);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
`ifdef PIPE_CTRL_PERF_EN
        // counters only cover the span since the mid-run reset
        total++;
        if (stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, 0);
        end
        total++;
        if (flush_cnt !== 32'd0) begin
            bad++;
            $display("FAIL flush_cnt: got %0d required %0d", flush_cnt, 0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
